// File: rtl/spi_aes_slave_frontend_if.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_aes_slave_frontend_if : SPI link + AES core handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface spi_aes_slave_frontend_if #(
  parameter int NK = 4
);
  localparam int KEY_W = NK * 32;

  logic             cs;
  logic             mosi;
  logic             mode;
  logic             miso;
  logic             core_start;
  logic [127:0]     core_msg;
  logic [KEY_W-1:0] core_key;
  logic             core_done;
  logic [127:0]     core_result;
  logic             result_ready;
  logic             frame_err;

  modport slave (
    input  cs, mosi, mode, core_done, core_result,
    output miso, core_start, core_msg, core_key, result_ready, frame_err
  );

  modport master (
    output cs, mosi, mode, core_done, core_result,
    input  miso, core_start, core_msg, core_key, result_ready, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_aes_slave_frontend.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_aes_slave_frontend : LSB-first SPI deserializer/serializer for AES core
// Rev 1.0
// ------------------------------------------------------------------
module spi_aes_slave_frontend #(
  parameter int NK    = 4,
  parameter int MSG_W = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_aes_slave_frontend_if.slave  bus
);
  localparam int KEY_W = NK * 32;
  localparam int CNT_W = $clog2((KEY_W > MSG_W) ? KEY_W : MSG_W);
  localparam int IDX_W = $clog2(MSG_W);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RX_MSG    = 3'd1;
  localparam logic [2:0] S_RX_KEY    = 3'd2;
  localparam logic [2:0] S_WAIT_CORE = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;
  localparam logic [2:0] S_TX        = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [MSG_W-1:0] core_msg_q, core_msg_d;
  logic [KEY_W-1:0] core_key_q, core_key_d;
  logic [MSG_W-1:0] result_q, result_d;
  logic             miso_q, miso_d;
  logic             start_q, start_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  logic rx_abort;
  logic msg_last;
  logic key_last;

  assign rx_abort = bus.cs | bus.mode;
  assign msg_last = (cnt_q == CNT_W'(MSG_W - 1));
  assign key_last = (cnt_q == CNT_W'(KEY_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      msg_q      <= '0;
      key_q      <= '0;
      core_msg_q <= '0;
      core_key_q <= '0;
      result_q   <= '0;
      miso_q     <= 1'b0;
      start_q    <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      msg_q      <= msg_d;
      key_q      <= key_d;
      core_msg_q <= core_msg_d;
      core_key_q <= core_key_d;
      result_q   <= result_d;
      miso_q     <= miso_d;
      start_q    <= start_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!bus.cs && !bus.mode) state_d = S_RX_MSG;
      S_RX_MSG:    if (rx_abort) state_d = S_IDLE;
                   else if (msg_last) state_d = S_RX_KEY;
      S_RX_KEY:    if (rx_abort) state_d = S_IDLE;
                   else if (key_last) state_d = S_WAIT_CORE;
      S_WAIT_CORE: if (bus.core_done) state_d = (bus.mode && !bus.cs) ? S_TX : S_HOLD;
      S_HOLD:      if (!bus.cs && bus.mode) state_d = S_TX;
      S_TX:        if (!bus.cs && msg_last) state_d = S_DONE;
      S_DONE:      if (bus.cs) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Bits enter at the MSB end and shift down, so the first bit lands at index 0.
  always_comb begin
    cnt_d      = cnt_q;
    msg_d      = msg_q;
    key_d      = key_q;
    core_msg_d = core_msg_q;
    core_key_d = core_key_q;
    result_d   = result_q;
    miso_d     = miso_q;
    start_d    = 1'b0;
    ready_d    = ready_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.cs && !bus.mode) begin
          msg_d = {bus.mosi, msg_q[MSG_W-1:1]};
          cnt_d = CNT_W'(1);
        end
      end
      S_RX_MSG: begin
        if (rx_abort) begin
          err_d = 1'b1;
        end else begin
          msg_d = {bus.mosi, msg_q[MSG_W-1:1]};
          cnt_d = msg_last ? '0 : cnt_q + 1'b1;
        end
      end
      S_RX_KEY: begin
        if (rx_abort) begin
          err_d = 1'b1;
        end else begin
          key_d = {bus.mosi, key_q[KEY_W-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (key_last) begin
            core_msg_d = msg_q;
            core_key_d = {bus.mosi, key_q[KEY_W-1:1]};
            start_d    = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      S_WAIT_CORE: begin
        if (bus.core_done) begin
          result_d = bus.core_result;
          ready_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      S_HOLD: begin
        if (!bus.cs && bus.mode) cnt_d = '0;
      end
      // While cs is high the counter and miso simply hold, so read-back resumes.
      S_TX: begin
        if (!bus.cs) begin
          miso_d = result_q[cnt_q[IDX_W-1:0]];
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        miso_d  = 1'b0;
        ready_d = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign bus.miso         = miso_q;
  assign bus.core_start   = start_q;
  assign bus.core_msg     = core_msg_q;
  assign bus.core_key     = core_key_q;
  assign bus.result_ready = ready_q;
  assign bus.frame_err    = err_q;
endmodule
`default_nettype wire
